par_to_ser_video_converter: RTL and testbench

Converts a parallel column stream (one pixel from each of `LINES_TO_OUTPUT` vertically adjacent lines per beat) back into a raster-order serial video stream, one line at a time. It sits on the decode/readback side of the JPEG pipeline and inverts the serial-to-parallel line grouping. A two-bank ping-pong stripe buffer lets the block accept stripe N+1 while it emits stripe N.

---
 rtl/par_to_ser_video_converter_pkg.sv | 12 +
 rtl/par_to_ser_video_converter_if.sv | 28 ++
 rtl/par_to_ser_video_converter_stripe_ram.sv | 32 +++
 rtl/par_to_ser_video_converter.sv | 247 ++++++++++++++++++++++++
 tb/tb_par_to_ser_video_converter.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/par_to_ser_video_converter_pkg.sv
// Shared definitions for the JPEG video path: bus width rounding and stripe bank count.
package jpeg_video_pkg;

  // Two stripe banks: one filling from the column stream while the other drains.
  localparam int BANKS = 2;

  // Round a bit width up to a whole number of bytes (AXI4-Stream tdata granularity).
  function automatic int byte_round(input int w);
    return ((w + 7) / 8) * 8;
  endfunction

endpackage

// File: rtl/par_to_ser_video_converter_if.sv
// AXI4-Stream bundle with master/slave views; tuser, tid and tdest are single bits.
interface axi4_stream_if #(
  parameter int DATA_W = 8
) ();

  localparam int STRB_W = (DATA_W + 7) / 8;

  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic [STRB_W-1:0] tstrb;
  logic [STRB_W-1:0] tkeep;
  logic              tlast;
  logic              tuser;
  logic              tid;
  logic              tdest;

  modport master (
    output tvalid, tdata, tstrb, tkeep, tlast, tuser, tid, tdest,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tstrb, tkeep, tlast, tuser, tid, tdest,
    output tready
  );

endinterface

// File: rtl/par_to_ser_video_converter_stripe_ram.sv
// Simple dual-port stripe store: one write port, one registered read port, no reset.
module par_to_ser_stripe_ram #(
  parameter int WIDTH  = 64,
  parameter int ADDR_W = 12
) (
  input  logic              clk_i,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  // The bank bit is the address MSB, so each bank owns a power-of-two block of rows.
  logic [WIDTH-1:0] mem [2**ADDR_W];

  // Column write from the input side.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read; output holds between reads.
  always_ff @(posedge clk_i) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/par_to_ser_video_converter.sv
// Parallel column stream to raster serial video, via a two-bank ping-pong stripe buffer.
module par_to_ser_video_converter
  import jpeg_video_pkg::*;
#(
  parameter int LINES_TO_OUTPUT = 8,
  parameter int PX_WIDTH        = 8,
  parameter int FRAME_RES_X     = 1280
) (
  input  logic          clk_i,
  input  logic          rst_i,
  axi4_stream_if.slave  parallel_video_i,
  axi4_stream_if.master video_o
);

  localparam int PAR_W   = byte_round(PX_WIDTH * LINES_TO_OUTPUT);
  localparam int TDATA_W = byte_round(PX_WIDTH);
  localparam int COL_W   = (FRAME_RES_X > 1) ? $clog2(FRAME_RES_X) : 1;
  localparam int LEN_W   = $clog2(FRAME_RES_X + 1);
  localparam int LINE_W  = (LINES_TO_OUTPUT > 1) ? $clog2(LINES_TO_OUTPUT) : 1;
  localparam int ADDR_W  = COL_W + 1;

  // Per-bank state
  logic [BANKS-1:0] full;
  logic [BANKS-1:0] sof;
  logic [LEN_W-1:0] len [BANKS];

  // Write-side pointers
  logic             wr_bank;
  logic [COL_W-1:0] wr_col;
  logic             wr_fire;
  logic             wr_close;

  // Read-side pointers
  logic              rd_bank;
  logic [LINE_W-1:0] rd_line;
  logic [COL_W-1:0]  rd_col;
  logic [LEN_W-1:0]  rd_len_m1;
  logic              rd_col_last;
  logic              rd_line_last;
  logic              rd_issue;
  logic              rd_release;
  logic              rd_user;

  // Read pipeline and output skid FIFO
  logic              vld_p0;
  logic [LINE_W-1:0] line_p0;
  logic              last_p0;
  logic              user_p0;
  logic [PAR_W-1:0]  ram_rdata;
  logic [PX_WIDTH-1:0] px_p1;
  logic [TDATA_W-1:0]  q_in;
  logic [TDATA_W-1:0]  q_data [2];
  logic [1:0]          q_last;
  logic [1:0]          q_user;
  logic [1:0]          q_cnt;
  logic [1:0]          cred;
  logic [1:0]          cred_after_pop;
  logic                push;
  logic                pop;

  // Sideband fields the converter has no use for on its input.
  logic unused_in_sideband;
  assign unused_in_sideband = ^{parallel_video_i.tstrb, parallel_video_i.tkeep,
                                parallel_video_i.tid, parallel_video_i.tdest};

  // ---------------- write side ----------------
  // tready depends only on registered bank state.
  assign parallel_video_i.tready = !full[wr_bank];
  assign wr_fire  = parallel_video_i.tvalid && parallel_video_i.tready;
  // A stripe also closes at the last physical column so overlong lines are truncated.
  assign wr_close = wr_fire &&
                    (parallel_video_i.tlast || (wr_col == COL_W'(FRAME_RES_X - 1)));

  // Write pointer: advance per accepted column, flip banks when a stripe closes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_bank <= 1'b0;
      wr_col  <= '0;
    end else if (wr_close) begin
      wr_bank <= ~wr_bank;
      wr_col  <= '0;
    end else if (wr_fire) begin
      wr_col <= wr_col + 1'b1;
    end
  end

  // ---------------- read side ----------------
  assign rd_len_m1    = len[rd_bank] - LEN_W'(1);
  assign rd_col_last  = (LEN_W'(rd_col) == rd_len_m1);
  assign rd_line_last = (rd_line == LINE_W'(LINES_TO_OUTPUT - 1));
  assign rd_user      = sof[rd_bank] && (rd_line == '0) && (rd_col == '0);

  // Credits cover reads in flight plus FIFO entries; a pop this cycle frees one now.
  assign pop            = (q_cnt != 2'd0) && video_o.tready;
  assign cred_after_pop = cred - {1'b0, pop};
  assign rd_issue       = full[rd_bank] && (cred_after_pop < 2'd2);
  assign rd_release     = rd_issue && rd_col_last && rd_line_last;

  // Read pointer: column within line, then line within stripe, then bank.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_bank <= 1'b0;
      rd_line <= '0;
      rd_col  <= '0;
    end else if (rd_issue) begin
      if (rd_col_last) begin
        rd_col <= '0;
        if (rd_line_last) begin
          rd_line <= '0;
          rd_bank <= ~rd_bank;
        end else begin
          rd_line <= rd_line + 1'b1;
        end
      end else begin
        rd_col <= rd_col + 1'b1;
      end
    end
  end

  // Bank flags: writer fills, reader releases; they never touch the same bank together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      full <= '0;
      sof  <= '0;
      for (int b = 0; b < BANKS; b++) begin
        len[b] <= '0;
      end
    end else begin
      for (int b = 0; b < BANKS; b++) begin
        if (wr_fire && (wr_bank == 1'(b)) && (wr_col == '0) && parallel_video_i.tuser) begin
          sof[b] <= 1'b1;
        end
        if (wr_close && (wr_bank == 1'(b))) begin
          full[b] <= 1'b1;
          len[b]  <= LEN_W'(wr_col) + LEN_W'(1);
        end
        if (rd_release && (rd_bank == 1'(b))) begin
          full[b] <= 1'b0;
          sof[b]  <= 1'b0;
        end
      end
    end
  end

  par_to_ser_stripe_ram #(
    .WIDTH  (PAR_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (clk_i),
    .wr_en   (wr_fire),
    .wr_addr ({wr_bank, wr_col}),
    .wr_data (parallel_video_i.tdata),
    .rd_en   (rd_issue),
    .rd_addr ({rd_bank, rd_col}),
    .rd_data (ram_rdata)
  );

  // ---- stage p0: read issued, RAM word in flight alongside its line/sideband ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p0 <= 1'b0;
    end else begin
      vld_p0 <= rd_issue;
    end
  end

  // Line select and sideband travel with the read; data path needs no reset.
  always_ff @(posedge clk_i) begin
    if (rd_issue) begin
      line_p0 <= rd_line;
      last_p0 <= rd_col_last;
      user_p0 <= rd_user;
    end
  end

  // ---- stage p1: pick this line's pixel out of the fetched column ----
  assign px_p1 = ram_rdata[int'(line_p0) * PX_WIDTH +: PX_WIDTH];
  assign q_in  = TDATA_W'(px_p1);
  assign push  = vld_p0;

  // Credit counter: +1 per issued read, -1 per accepted output pixel.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cred <= 2'd0;
    end else begin
      cred <= cred + {1'b0, rd_issue} - {1'b0, pop};
    end
  end

  // Two-entry skid FIFO; slot 0 drives the output and only moves on a pop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_cnt     <= 2'd0;
      q_data[0] <= '0;
      q_data[1] <= '0;
      q_last    <= '0;
      q_user    <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (q_cnt == 2'd0) begin
            q_data[0] <= q_in;
            q_last[0] <= last_p0;
            q_user[0] <= user_p0;
          end else begin
            q_data[1] <= q_in;
            q_last[1] <= last_p0;
            q_user[1] <= user_p0;
          end
          q_cnt <= q_cnt + 2'd1;
        end
        2'b01: begin
          q_data[0] <= q_data[1];
          q_last[0] <= q_last[1];
          q_user[0] <= q_user[1];
          q_cnt     <= q_cnt - 2'd1;
        end
        2'b11: begin
          if (q_cnt == 2'd1) begin
            q_data[0] <= q_in;
            q_last[0] <= last_p0;
            q_user[0] <= user_p0;
          end else begin
            q_data[0] <= q_data[1];
            q_last[0] <= q_last[1];
            q_user[0] <= q_user[1];
            q_data[1] <= q_in;
            q_last[1] <= last_p0;
            q_user[1] <= user_p0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign video_o.tvalid = (q_cnt != 2'd0);
  assign video_o.tdata  = q_data[0];
  assign video_o.tlast  = q_last[0];
  assign video_o.tuser  = q_user[0];
  assign video_o.tstrb  = '1;
  assign video_o.tkeep  = '1;
  assign video_o.tid    = 1'b0;
  assign video_o.tdest  = 1'b0;

endmodule

// File: tb/tb_par_to_ser_video_converter.sv
// Directed bench for par_to_ser_video_converter with a pixel scoreboard.
module tb_par_to_ser_video_converter;

  localparam int L   = 4;
  localparam int PX  = 8;
  localparam int FRX = 4;

  logic clk;
  logic rst;
  int   cyc;
  int   total;
  int   bad;

  axi4_stream_if #(.DATA_W(32)) par_if ();
  axi4_stream_if #(.DATA_W(8))  ser_if ();

  par_to_ser_video_converter #(
    .LINES_TO_OUTPUT (L),
    .PX_WIDTH        (PX),
    .FRAME_RES_X     (FRX)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .parallel_video_i (par_if),
    .video_o          (ser_if)
  );

  // Scoreboard entries: {tuser, tlast, tdata}
  logic [9:0] sb [$];
  bit   mon_en;
  bit   bp_en;
  bit   mark_first;
  int   out_cnt;
  int   first_pop_cyc;
  int   last_pop_cyc;
  int   first_hs_cyc;
  int   hs_cyc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_beat(input logic [7:0] seed, input int col);
    logic [31:0] w;
    for (int l = 0; l < L; l++) begin
      w[l*8 +: 8] = seed + 8'(col * 16) + 8'(l);
    end
    return w;
  endfunction

  // Output ready: always high, or ~30% duty when backpressure is enabled.
  initial begin
    ser_if.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ser_if.tready = bp_en ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  // Output monitor: pops the scoreboard on each handshake, checks hold while stalled.
  initial begin
    bit         stall_prev;
    logic [9:0] held;
    logic [9:0] exp;
    stall_prev = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check("hold", {ser_if.tvalid, ser_if.tuser, ser_if.tlast, ser_if.tdata},
                {1'b1, held});
        end
        if (ser_if.tvalid && ser_if.tready) begin
          if (sb.size() == 0) begin
            check("extra_px", {ser_if.tuser, ser_if.tlast, ser_if.tdata}, 64'hDEAD);
          end else begin
            exp = sb.pop_front();
            check("px", {ser_if.tuser, ser_if.tlast, ser_if.tdata}, exp);
          end
          out_cnt++;
          last_pop_cyc = cyc;
          if (mark_first) begin
            first_pop_cyc = cyc;
            mark_first = 1'b0;
          end
        end
        stall_prev = ser_if.tvalid && !ser_if.tready;
        held = {ser_if.tuser, ser_if.tlast, ser_if.tdata};
      end
    end
  end

  // Sends one stripe of n columns starting at a negedge; returns at a negedge.
  task automatic send_stripe(input logic [7:0] seed, input int n, input bit tl, input bit sf);
    int w;
    for (int ln = 0; ln < L; ln++) begin
      for (int c = 0; c < n; c++) begin
        sb.push_back({(sf && ln == 0 && c == 0), (c == n - 1),
                      8'(seed + 8'(c * 16) + 8'(ln))});
      end
    end
    for (int c = 0; c < n; c++) begin
      par_if.tdata  = mk_beat(seed, c);
      par_if.tlast  = tl && (c == n - 1);
      par_if.tuser  = sf && (c == 0);
      par_if.tvalid = 1'b1;
      w = 0;
      while (!par_if.tready && w < 500) begin
        @(negedge clk);
        w++;
      end
      if (w >= 500) begin
        check("in_tready_timeout", 0, 1);
        break;
      end
      @(posedge clk);
      @(negedge clk);
      hs_cyc = cyc;
      if (c == 0) first_hs_cyc = cyc;
    end
    par_if.tvalid = 1'b0;
    par_if.tlast  = 1'b0;
    par_if.tuser  = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || ser_if.tvalid) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(tag, sb.size(), 0);
  endtask

  initial begin
    int close1;
    int start_cnt;
    int n;
    total = 0; bad = 0; out_cnt = 0;
    mon_en = 1'b0; bp_en = 1'b0; mark_first = 1'b0;
    first_pop_cyc = 0; last_pop_cyc = 0; first_hs_cyc = 0; hs_cyc = 0;
    par_if.tvalid = 1'b0; par_if.tdata = '0; par_if.tlast = 1'b0; par_if.tuser = 1'b0;
    par_if.tstrb = '1; par_if.tkeep = '1; par_if.tid = 1'b0; par_if.tdest = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_tvalid", ser_if.tvalid, 0);
    check("rst_tlast", ser_if.tlast, 0);
    check("rst_tuser", ser_if.tuser, 0);
    check("rst_tdata", ser_if.tdata, 0);
    check("rst_in_tready", par_if.tready, 1);
    mon_en = 1'b1;

    // Single stripe with latency check
    send_stripe(8'h00, 4, 1'b1, 1'b1);
    check("lat_e0", ser_if.tvalid, 0);
    @(negedge clk);
    check("lat_e1", ser_if.tvalid, 0);
    @(negedge clk);
    check("lat_e2", ser_if.tvalid, 1);
    check("first_px", {ser_if.tuser, ser_if.tlast, ser_if.tdata}, {2'b10, 8'h00});
    wait_drain("single_drain");

    // Ping-pong: three back-to-back stripes
    mark_first = 1'b1;
    start_cnt = out_cnt;
    send_stripe(8'h40, 4, 1'b1, 1'b1);
    close1 = hs_cyc;
    send_stripe(8'h80, 4, 1'b1, 1'b0);
    check("pp_tready_low", par_if.tready, 0);
    send_stripe(8'hC0, 4, 1'b1, 1'b0);
    check("pp_tready_return", first_hs_cyc - close1, 17);
    wait_drain("pp_drain");
    check("pp_count", out_cnt - start_cnt, 48);
    check("pp_continuous", last_pop_cyc - first_pop_cyc, 47);

    // Backpressure
    bp_en = 1'b1;
    start_cnt = out_cnt;
    send_stripe(8'h08, 4, 1'b1, 1'b1);
    send_stripe(8'h88, 4, 1'b1, 1'b0);
    wait_drain("bp_drain");
    check("bp_count", out_cnt - start_cnt, 32);
    bp_en = 1'b0;
    repeat (2) @(negedge clk);

    // Short line then full line
    start_cnt = out_cnt;
    send_stripe(8'h20, 2, 1'b1, 1'b1);
    send_stripe(8'hA0, 4, 1'b1, 1'b0);
    wait_drain("short_drain");
    check("short_count", out_cnt - start_cnt, 24);

    // Overlong: two 4-beat runs without tlast
    start_cnt = out_cnt;
    send_stripe(8'h44, 4, 1'b0, 1'b1);
    send_stripe(8'h84, 4, 1'b0, 1'b0);
    wait_drain("overlong_drain");
    check("overlong_count", out_cnt - start_cnt, 32);

    // Mid-operation reset
    start_cnt = out_cnt;
    send_stripe(8'h60, 4, 1'b1, 1'b1);
    n = 0;
    while (out_cnt < start_cnt + 6 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("mid_reach", (out_cnt >= start_cnt + 6), 1);
    mon_en = 1'b0;
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("mrst_tvalid", ser_if.tvalid, 0);
    check("mrst_in_tready", par_if.tready, 1);
    mon_en = 1'b1;
    start_cnt = out_cnt;
    send_stripe(8'hE0, 4, 1'b1, 1'b1);
    wait_drain("mrst_drain");
    check("mrst_count", out_cnt - start_cnt, 16);
    repeat (5) @(negedge clk);
    check("idle_tvalid", ser_if.tvalid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
